// File: rtl/load_use_stall_unit_if.sv
// Control-path bundle between the ID/ALU pipeline registers and the stall/flush controller.
// The master modport is the pipeline side; the slave modport is the controller.
interface load_use_stall_unit_if #(
  parameter int STALL_CNT_WIDTH = 16
);
  logic [4:0]                 rs1_address_id_stage;
  logic [4:0]                 rs2_address_id_stage;
  logic                       rs1_used_id_stage;
  logic                       rs2_used_id_stage;
  logic [4:0]                 destination_address_alu_stage;
  logic                       mem_read_alu_stage;
  logic                       reg_write_alu_stage;
  logic                       data_memory_busy;
  logic                       branch_taken_alu_stage;

  logic                       pc_write_enable;
  logic                       if_id_write_enable;
  logic                       id_alu_bubble;
  logic                       if_id_flush;
  logic                       pipeline_freeze;
  logic [STALL_CNT_WIDTH-1:0] stall_count;

  modport master (
    output rs1_address_id_stage, rs2_address_id_stage,
    output rs1_used_id_stage, rs2_used_id_stage,
    output destination_address_alu_stage, mem_read_alu_stage, reg_write_alu_stage,
    output data_memory_busy, branch_taken_alu_stage,
    input  pc_write_enable, if_id_write_enable, id_alu_bubble,
    input  if_id_flush, pipeline_freeze, stall_count
  );

  modport slave (
    input  rs1_address_id_stage, rs2_address_id_stage,
    input  rs1_used_id_stage, rs2_used_id_stage,
    input  destination_address_alu_stage, mem_read_alu_stage, reg_write_alu_stage,
    input  data_memory_busy, branch_taken_alu_stage,
    output pc_write_enable, if_id_write_enable, id_alu_bubble,
    output if_id_flush, pipeline_freeze, stall_count
  );
endinterface

// File: rtl/load_use_stall_unit.sv
// Stall/flush controller for the ID->ALU boundary: one bubble per load-use pair,
// whole-pipe freeze while data memory is busy, ID squash on a taken branch.
//
// state      | meaning
// RUN        | normal flow, load-use hazards checked
// LOAD_STALL | bubble issued last cycle, hazard ignored (forwarding covers it)
// MEM_WAIT   | pipe was frozen last cycle, behaves as RUN once busy drops
module load_use_stall_unit #(
  parameter int STALL_CNT_WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  load_use_stall_unit_if.slave bus
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT   = 2'd2;

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]                 state;
  logic [1:0]                 next_state;
  logic [STALL_CNT_WIDTH-1:0] stall_count_q;

  logic load_in_alu;
  logic rs1_match;
  logic rs2_match;
  logic hazard;

  // A load to x0 never produces data anyone can depend on.
  always_comb begin
    load_in_alu = bus.mem_read_alu_stage & bus.reg_write_alu_stage &
                  (bus.destination_address_alu_stage != 5'd0);
    rs1_match   = bus.rs1_used_id_stage &
                  (bus.rs1_address_id_stage == bus.destination_address_alu_stage);
    rs2_match   = bus.rs2_used_id_stage &
                  (bus.rs2_address_id_stage == bus.destination_address_alu_stage);
    hazard      = load_in_alu & (rs1_match | rs2_match);
  end

  always_comb begin
    bus.pc_write_enable    = 1'b1;
    bus.if_id_write_enable = 1'b1;
    bus.id_alu_bubble      = 1'b0;
    bus.if_id_flush        = 1'b0;
    bus.pipeline_freeze    = 1'b0;
    next_state             = RUN;

    if (reset) begin
      bus.pc_write_enable    = 1'b0;
      bus.if_id_write_enable = 1'b0;
      bus.id_alu_bubble      = 1'b1;
      bus.if_id_flush        = 1'b1;
    end else if (bus.data_memory_busy) begin
      bus.pc_write_enable    = 1'b0;
      bus.if_id_write_enable = 1'b0;
      bus.pipeline_freeze    = 1'b1;
      next_state             = MEM_WAIT;
    end else if (bus.branch_taken_alu_stage) begin
      bus.id_alu_bubble      = 1'b1;
      bus.if_id_flush        = 1'b1;
    end else if (hazard && state != LOAD_STALL) begin
      // MEM_WAIT lands here too, so a pair frozen mid-stall still gets its bubble.
      bus.pc_write_enable    = 1'b0;
      bus.if_id_write_enable = 1'b0;
      bus.id_alu_bubble      = 1'b1;
      next_state             = LOAD_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      stall_count_q <= '0;
    end else begin
      state <= next_state;
      if (!bus.pc_write_enable && stall_count_q != CNT_MAX)
        stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_load_use_stall_unit.sv
// Bench for load_use_stall_unit: directed test-plan scenarios plus randomized traffic
// checked against a rule-level model; a 4-bit counter instance covers saturation.
module tb_load_use_stall_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_use_stall_unit_if #(.STALL_CNT_WIDTH(16)) bus ();
  load_use_stall_unit_if #(.STALL_CNT_WIDTH(4))  bus4 ();

  assign bus4.rs1_address_id_stage          = bus.rs1_address_id_stage;
  assign bus4.rs2_address_id_stage          = bus.rs2_address_id_stage;
  assign bus4.rs1_used_id_stage             = bus.rs1_used_id_stage;
  assign bus4.rs2_used_id_stage             = bus.rs2_used_id_stage;
  assign bus4.destination_address_alu_stage = bus.destination_address_alu_stage;
  assign bus4.mem_read_alu_stage            = bus.mem_read_alu_stage;
  assign bus4.reg_write_alu_stage           = bus.reg_write_alu_stage;
  assign bus4.data_memory_busy              = bus.data_memory_busy;
  assign bus4.branch_taken_alu_stage        = bus.branch_taken_alu_stage;

  load_use_stall_unit #(.STALL_CNT_WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  load_use_stall_unit #(.STALL_CNT_WIDTH(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  logic [4:0] outs;
  assign outs = {bus.pc_write_enable, bus.if_id_write_enable, bus.id_alu_bubble,
                 bus.if_id_flush, bus.pipeline_freeze};

  int checks = 0;
  int errors = 0;

  // Model state: whether the last cycle was a load-use bubble, and stall totals.
  bit m_prev_bubble;
  int m_cnt;
  int m_cnt4;

  // Returns {took_load_bubble, pc_we, if_id_we, bubble, flush, freeze}.
  function automatic logic [5:0] model_ctrl();
    bit h;
    h = bus.mem_read_alu_stage && bus.reg_write_alu_stage &&
        bus.destination_address_alu_stage != 0 &&
        ((bus.rs1_used_id_stage && bus.rs1_address_id_stage == bus.destination_address_alu_stage) ||
         (bus.rs2_used_id_stage && bus.rs2_address_id_stage == bus.destination_address_alu_stage));
    if (reset)                      return 6'b0_00110;
    if (bus.data_memory_busy)       return 6'b0_00001;
    if (bus.branch_taken_alu_stage) return 6'b0_11110;
    if (h && !m_prev_bubble)        return 6'b1_00100;
    return 6'b0_11000;
  endfunction

  task automatic drive(input logic rst, input logic busy, input logic br,
                       input logic ld, input logic wr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    reset                             = rst;
    bus.data_memory_busy              = busy;
    bus.branch_taken_alu_stage        = br;
    bus.mem_read_alu_stage            = ld;
    bus.reg_write_alu_stage           = wr;
    bus.destination_address_alu_stage = rd;
    bus.rs1_address_id_stage          = rs1;
    bus.rs1_used_id_stage             = u1;
    bus.rs2_address_id_stage          = rs2;
    bus.rs2_used_id_stage             = u2;
  endtask

  // Advance one clock and update the model with the inputs of the cycle just ended.
  task automatic step();
    logic [5:0] e;
    e = model_ctrl();
    @(posedge clk);
    if (reset) begin
      m_prev_bubble = 0;
      m_cnt = 0;
      m_cnt4 = 0;
    end else begin
      if (!e[4]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_prev_bubble = e[5];
    end
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] e;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(1, 1, 1, 1, 1, 5, 5, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 5'b00110) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 5'b00110);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    e = model_ctrl();
    checks++;
    if (outs !== e[4:0] || bus.stall_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got outs=%b cnt=%0d expected outs=%b cnt=0", outs, bus.stall_count, e[4:0]);
    end
    step();
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 1, 5, 5, 1, 7, 1);
    @(negedge clk);
    checks++;
    if (outs !== 5'b00100) begin
      errors++;
      $display("FAIL load_use_bubble: got %b expected %b", outs, 5'b00100);
    end
    step();
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000 || bus.stall_count !== 16'd1) begin
      errors++;
      $display("FAIL load_use_release: got outs=%b cnt=%0d expected outs=11000 cnt=1", outs, bus.stall_count);
    end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000 || bus.stall_count !== 16'd1) begin
      errors++;
      $display("FAIL load_use_after: got outs=%b cnt=%0d expected outs=11000 cnt=1", outs, bus.stall_count);
    end
    step();
  endtask

  task automatic test_no_stall();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 1, 0, 0, 1, 0, 1);
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000) begin
      errors++;
      $display("FAIL no_stall_x0: got %b expected %b", outs, 5'b11000);
    end
    step();
    drive(0, 0, 0, 1, 1, 5, 3, 1, 5, 0);
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000) begin
      errors++;
      $display("FAIL no_stall_rs2_unused: got %b expected %b", outs, 5'b11000);
    end
    step();
    drive(0, 0, 0, 0, 1, 5, 5, 1, 5, 1);
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000 || bus.stall_count !== 16'd0) begin
      errors++;
      $display("FAIL no_stall_not_load: got outs=%b cnt=%0d expected outs=11000 cnt=0", outs, bus.stall_count);
    end
    step();
  endtask

  task automatic test_branch_priority();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 1, 1, 1, 9, 1, 0, 9, 1);
    @(negedge clk);
    checks++;
    if (outs !== 5'b11110) begin
      errors++;
      $display("FAIL branch_over_hazard: got %b expected %b", outs, 5'b11110);
    end
    step();
    drive(0, 0, 0, 1, 1, 9, 1, 0, 9, 1);
    @(negedge clk);
    checks++;
    if (outs !== 5'b00100 || bus.stall_count !== 16'd0) begin
      errors++;
      $display("FAIL branch_no_load_stall: got outs=%b cnt=%0d expected outs=00100 cnt=0", outs, bus.stall_count);
    end
    step();
  endtask

  task automatic test_busy_freeze();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 1, 12, 12, 1, 0, 0);
      @(negedge clk);
      checks++;
      if (outs !== 5'b00001) begin
        errors++;
        $display("FAIL busy_freeze[%0d]: got %b expected %b", i, outs, 5'b00001);
      end
      step();
    end
    drive(0, 0, 0, 1, 1, 12, 12, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 5'b00100) begin
      errors++;
      $display("FAIL busy_then_bubble: got %b expected %b", outs, 5'b00100);
    end
    step();
    @(negedge clk);
    checks++;
    if (outs !== 5'b11000 || bus.stall_count !== 16'd4) begin
      errors++;
      $display("FAIL busy_then_normal: got outs=%b cnt=%0d expected outs=11000 cnt=4", outs, bus.stall_count);
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 1, 3, 3, 1, 0, 0);
    step();
    drive(1, 0, 0, 1, 1, 3, 3, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 5'b00110) begin
      errors++;
      $display("FAIL reset_mid_stall: got %b expected %b", outs, 5'b00110);
    end
    step();
    drive(0, 0, 0, 1, 1, 3, 3, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (outs !== 5'b00100 || bus.stall_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_then_run: got outs=%b cnt=%0d expected outs=00100 cnt=0", outs, bus.stall_count);
    end
    step();
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (bus4.stall_count !== 4'((i > 15) ? 15 : i) || bus.stall_count !== 16'(i)) begin
        errors++;
        $display("FAIL saturation[%0d]: got cnt4=%0d cnt16=%0d expected cnt4=%0d cnt16=%0d",
                 i, bus4.stall_count, bus.stall_count, (i > 15) ? 15 : i, i);
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus4.stall_count !== 4'd15 || bus.stall_count !== 16'd20) begin
      errors++;
      $display("FAIL saturation_hold: got cnt4=%0d cnt16=%0d expected cnt4=15 cnt16=20", bus4.stall_count, bus.stall_count);
    end
    step();
  endtask

  task automatic test_random();
    logic [5:0] e;
    for (int i = 0; i < 600; i++) begin
      drive(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 4) == 0),
            logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), logic'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), logic'($urandom_range(0, 1)));
      @(negedge clk);
      e = model_ctrl();
      checks++;
      if (outs !== e[4:0] || bus.stall_count !== 16'(m_cnt) || bus4.stall_count !== 4'(m_cnt4)) begin
        errors++;
        $display("FAIL random[%0d]: got outs=%b cnt=%0d cnt4=%0d expected outs=%b cnt=%0d cnt4=%0d",
                 i, outs, bus.stall_count, bus4.stall_count, e[4:0], m_cnt, m_cnt4);
      end
      step();
    end
  endtask

  initial begin
    m_prev_bubble = 0;
    m_cnt = 0;
    m_cnt4 = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_priority();
    test_busy_freeze();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
